// File: rtl/pipeline_sequencer_pkg.sv
// Shared encodings for the pipeline sequencer: stage numbers, one-hot enable
// indices, FSM state codes and the width of the warmup/stall counters.
package pipeline_sequencer_pkg;

    localparam logic [1:0] STAGE_IF = 2'd0;
    localparam logic [1:0] STAGE_ID = 2'd1;
    localparam logic [1:0] STAGE_EX = 2'd2;
    localparam logic [1:0] STAGE_WB = 2'd3;

    localparam int ONEHOT_IF = 0;
    localparam int ONEHOT_ID = 1;
    localparam int ONEHOT_EX = 2;
    localparam int ONEHOT_WB = 3;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        SEQ_WARMUP    = 3'd0,
        SEQ_RUN       = 3'd1,
        SEQ_STALL     = 3'd2,
        SEQ_STEP_WAIT = 3'd3,
        SEQ_HALT      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_cycle_counter.sv
// Up-counter with synchronous clear/increment and a fixed terminal compare.
// clear together with incr loads 1, which is how a fresh stall is counted.
module pipeline_sequencer_cycle_counter #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TERMINAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic at_terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || incr) begin
            count <= (clear ? '0 : count) + {{(WIDTH-1){1'b0}}, incr};
        end
    end

    assign at_terminal = (count == TERMINAL);

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: issues one-hot per-stage enables and handles warmup,
// RAM stalls with timeout, sticky error halt and single-step debug.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int INITIAL_DELAY = 0,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_stall_req,
    input  logic        error_in,
    input  logic        step_mode,
    input  logic        step_req,
    output logic        stage_if_en,
    output logic        stage_id_en,
    output logic        stage_ex_en,
    output logic        stage_wb_en,
    output logic [1:0]  current_stage,
    output logic        halted,
    output logic        stall_timeout_error,
    output logic [31:0] retired_count
);

    seq_state_t state;
    seq_state_t next_state;

    logic [3:0] en_onehot;
    logic       run_ok;
    logic       warm_incr;
    logic       warm_done;
    logic       stall_clear;
    logic       stall_incr;
    logic       stall_done;
    logic       timeout_set;

    pipeline_sequencer_cycle_counter #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (CNT_WIDTH'(INITIAL_DELAY))
    ) u_warm_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (1'b0),
        .incr        (warm_incr),
        .at_terminal (warm_done)
    );

    pipeline_sequencer_cycle_counter #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (CNT_WIDTH'(STALL_TIMEOUT))
    ) u_stall_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (stall_clear),
        .incr        (stall_incr),
        .at_terminal (stall_done)
    );

    assign run_ok      = (state == SEQ_RUN) && !mem_stall_req && !error_in;
    assign en_onehot   = run_ok ? (4'b0001 << current_stage) : 4'b0000;
    assign stage_if_en = en_onehot[ONEHOT_IF];
    assign stage_id_en = en_onehot[ONEHOT_ID];
    assign stage_ex_en = en_onehot[ONEHOT_EX];
    assign stage_wb_en = en_onehot[ONEHOT_WB];
    assign halted      = (state == SEQ_HALT);

    always_comb begin
        next_state  = state;
        warm_incr   = 1'b0;
        stall_clear = 1'b0;
        stall_incr  = 1'b0;
        timeout_set = 1'b0;
        case (state)
            SEQ_WARMUP: begin
                if (warm_done) next_state = SEQ_RUN;
                else           warm_incr  = 1'b1;
            end
            SEQ_RUN: begin
                if (error_in) begin
                    next_state = SEQ_HALT;
                end else if (mem_stall_req) begin
                    next_state  = SEQ_STALL;
                    stall_clear = 1'b1;
                    stall_incr  = 1'b1;
                end else if (stage_wb_en && step_mode) begin
                    next_state = SEQ_STEP_WAIT;
                end
            end
            SEQ_STALL: begin
                // Release is checked before timeout so a stall of exactly
                // STALL_TIMEOUT cycles still resumes.
                if (error_in) begin
                    next_state = SEQ_HALT;
                end else if (!mem_stall_req) begin
                    next_state = SEQ_RUN;
                end else if (stall_done) begin
                    next_state  = SEQ_HALT;
                    timeout_set = 1'b1;
                end else begin
                    stall_incr = 1'b1;
                end
            end
            SEQ_STEP_WAIT: begin
                if (error_in)                    next_state = SEQ_HALT;
                else if (step_req || !step_mode) next_state = SEQ_RUN;
            end
            SEQ_HALT: next_state = SEQ_HALT;
            default:  next_state = SEQ_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= SEQ_WARMUP;
            current_stage       <= STAGE_IF;
            retired_count       <= '0;
            stall_timeout_error <= 1'b0;
        end else begin
            state <= next_state;
            if (run_ok) begin
                current_stage <= current_stage + 2'd1;
            end
            if (stage_wb_en) begin
                retired_count <= retired_count + 32'd1;
            end
            if (timeout_set) begin
                stall_timeout_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench: u_main (INITIAL_DELAY=3, STALL_TIMEOUT=255) covers warmup,
// stall, step and error paths; u_to (INITIAL_DELAY=0, STALL_TIMEOUT=4) covers timeout.
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_stall_req, error_in, step_mode, step_req;
    logic        m_if, m_id, m_ex, m_wb, m_halted, m_err;
    logic [1:0]  m_stage;
    logic [31:0] m_ret;
    logic [3:0]  m_en;

    logic        to_stall_req;
    logic        t_if, t_id, t_ex, t_wb, t_halted, t_err;
    logic [1:0]  t_stage;
    logic [31:0] t_ret;
    logic [3:0]  t_en;

    int checks   = 0;
    int failures = 0;

    assign m_en = {m_wb, m_ex, m_id, m_if};
    assign t_en = {t_wb, t_ex, t_id, t_if};

    pipeline_sequencer #(.INITIAL_DELAY(3), .STALL_TIMEOUT(255)) u_main (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_stall_req       (mem_stall_req),
        .error_in            (error_in),
        .step_mode           (step_mode),
        .step_req            (step_req),
        .stage_if_en         (m_if),
        .stage_id_en         (m_id),
        .stage_ex_en         (m_ex),
        .stage_wb_en         (m_wb),
        .current_stage       (m_stage),
        .halted              (m_halted),
        .stall_timeout_error (m_err),
        .retired_count       (m_ret)
    );

    pipeline_sequencer #(.INITIAL_DELAY(0), .STALL_TIMEOUT(4)) u_to (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_stall_req       (to_stall_req),
        .error_in            (1'b0),
        .step_mode           (1'b0),
        .step_req            (1'b0),
        .stage_if_en         (t_if),
        .stage_id_en         (t_id),
        .stage_ex_en         (t_ex),
        .stage_wb_en         (t_wb),
        .current_stage       (t_stage),
        .halted              (t_halted),
        .stall_timeout_error (t_err),
        .retired_count       (t_ret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        mem_stall_req = 1'b0;
        error_in      = 1'b0;
        step_mode     = 1'b0;
        step_req      = 1'b0;
        to_stall_req  = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        mem_stall_req = 1'b0;
        error_in      = 1'b0;
        step_mode     = 1'b0;
        step_req      = 1'b0;
        to_stall_req  = 1'b0;
        repeat (2) step();
        checks++;
        if ({m_en, m_stage, m_halted, m_err} !== 8'b0 || m_ret !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: en=%b stage=%0d halted=%b err=%b ret=%0d required all zero",
                     m_en, m_stage, m_halted, m_err, m_ret);
        end
        rst_n = 1'b1;
    endtask

    // Continues straight from test_reset's release: 4 warmup cycles, then IF..WB, IF.
    task automatic test_warmup();
        logic [3:0] exp_en [9];
        exp_en = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (m_en !== exp_en[c] || m_ret !== ((c == 8) ? 32'd1 : 32'd0)) begin
                failures++;
                $display("FAIL warmup_seq c=%0d: en=%b ret=%0d required en=%b ret=%0d",
                         c, m_en, m_ret, exp_en[c], (c == 8) ? 1 : 0);
            end
            if (c < 8) step();
        end
    endtask

    task automatic test_stall();
        step();
        step();
        checks++;
        if (m_en !== 4'b0100) begin
            failures++;
            $display("FAIL stall_pre_ex: en=%b required 0100", m_en);
        end
        mem_stall_req = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_en !== 4'b0000 || m_stage !== 2'd2 || m_halted !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold i=%0d: en=%b stage=%0d halted=%b required 0000/2/0",
                         i, m_en, m_stage, m_halted);
            end
            if (i < 4) step();
        end
        mem_stall_req = 1'b0;
        #1;
        checks++;
        if (m_en !== 4'b0000) begin
            failures++;
            $display("FAIL stall_release_same_cycle: en=%b required 0000", m_en);
        end
        step();
        checks++;
        if (m_en !== 4'b0100 || m_stage !== 2'd2 || m_err !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume: en=%b stage=%0d err=%b required 0100/2/0", m_en, m_stage, m_err);
        end
        step();
        step();
        checks++;
        if (m_ret !== 32'd2 || m_en !== 4'b0001) begin
            failures++;
            $display("FAIL stall_retire: ret=%0d en=%b required 2/0001", m_ret, m_en);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        to_stall_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (t_halted !== (k >= 6) || t_err !== (k >= 6) || t_en !== 4'b0000) begin
                failures++;
                $display("FAIL timeout_seq k=%0d: halted=%b err=%b en=%b required %b/%b/0000",
                         k, t_halted, t_err, t_en, k >= 6, k >= 6);
            end
        end
        to_stall_req = 1'b0;
        repeat (3) step();
        checks++;
        if (t_halted !== 1'b1 || t_err !== 1'b1 || t_en !== 4'b0000 || t_stage !== 2'd0 || t_ret !== 32'd0) begin
            failures++;
            $display("FAIL timeout_sticky: halted=%b err=%b en=%b stage=%0d ret=%0d required 1/1/0000/0/0",
                     t_halted, t_err, t_en, t_stage, t_ret);
        end
    endtask

    task automatic test_stall_boundary();
        do_reset();
        to_stall_req = 1'b1;
        repeat (5) step();
        checks++;
        if (t_halted !== 1'b0) begin
            failures++;
            $display("FAIL boundary_pre: halted=%b required 0", t_halted);
        end
        to_stall_req = 1'b0;
        step();
        checks++;
        if (t_halted !== 1'b0 || t_err !== 1'b0 || t_en !== 4'b0001) begin
            failures++;
            $display("FAIL boundary_resume: halted=%b err=%b en=%b required 0/0/0001", t_halted, t_err, t_en);
        end
    endtask

    task automatic test_step_mode();
        do_reset();
        step_mode = 1'b1;
        repeat (7) step();
        checks++;
        if (m_en !== 4'b1000) begin
            failures++;
            $display("FAIL step_first_wb: en=%b required 1000", m_en);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_en !== 4'b0000 || m_stage !== 2'd0 || m_ret !== 32'd1) begin
                failures++;
                $display("FAIL step_wait i=%0d: en=%b stage=%0d ret=%0d required 0000/0/1", i, m_en, m_stage, m_ret);
            end
            step();
        end
        for (int p = 1; p <= 2; p++) begin
            step_req = 1'b1;
            step();
            step_req = 1'b0;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (m_en !== (4'b0001 << k)) begin
                    failures++;
                    $display("FAIL step_pulse p=%0d k=%0d: en=%b required %b", p, k, m_en, 4'b0001 << k);
                end
                step();
            end
            step();
            checks++;
            if (m_en !== 4'b0000 || m_stage !== 2'd0 || m_ret !== 32'd1 + 32'(p)) begin
                failures++;
                $display("FAIL step_after p=%0d: en=%b stage=%0d ret=%0d required 0000/0/%0d",
                         p, m_en, m_stage, m_ret, 1 + p);
            end
        end
    endtask

    task automatic test_error_stall();
        do_reset();
        repeat (5) step();
        checks++;
        if (m_en !== 4'b0010) begin
            failures++;
            $display("FAIL err_pre_id: en=%b required 0010", m_en);
        end
        error_in      = 1'b1;
        mem_stall_req = 1'b1;
        #1;
        checks++;
        if (m_en !== 4'b0000) begin
            failures++;
            $display("FAIL err_en_drop: en=%b required 0000", m_en);
        end
        step();
        error_in      = 1'b0;
        mem_stall_req = 1'b0;
        repeat (3) step();
        checks++;
        if (m_halted !== 1'b1 || m_stage !== 2'd1 || m_en !== 4'b0000 || m_ret !== 32'd0 || m_err !== 1'b0) begin
            failures++;
            $display("FAIL err_halt: halted=%b stage=%0d en=%b ret=%0d err=%b required 1/1/0000/0/0",
                     m_halted, m_stage, m_en, m_ret, m_err);
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        repeat (6) step();
        force u_main.retired_count = 32'hFFFF_FFFF;
        #1;
        release u_main.retired_count;
        #1;
        checks++;
        if (m_ret !== 32'hFFFF_FFFF || m_en !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_preload: ret=%h en=%b required ffffffff/0100", m_ret, m_en);
        end
        step();
        step();
        checks++;
        if (m_ret !== 32'd0 || m_en !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_zero: ret=%h en=%b required 00000000/0001", m_ret, m_en);
        end
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_en, m_stage, m_halted, m_err} !== 8'b0 || m_ret !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: en=%b stage=%0d halted=%b err=%b ret=%0d required all zero",
                     m_en, m_stage, m_halted, m_err, m_ret);
        end
        rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if (m_en !== 4'b0001) begin
            failures++;
            $display("FAIL restart_if: en=%b required 0001", m_en);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_warmup();
        test_stall();
        test_timeout();
        test_stall_boundary();
        test_step_mode();
        test_error_stall();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
